mul4_share_ctrl: RTL

//  Shares one combinational 4x4 unsigned array multiplier core (Arraymultiplier4bit) between NREQ requesters.

---
 rtl/mul_arb_pkg.sv | 14 +
 rtl/arraymultiplier4bit.sv | 19 +
 rtl/mul4_share_ctrl_rr_arbiter.sv | 31 +++
 rtl/mul4_share_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the shared 4x4 multiplier controller.
// State encoding and operand/product widths live here.
package mul_arb_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/arraymultiplier4bit.sv
// Combinational 4x4 unsigned array multiplier core.
// Sums shifted partial products row by row.
module Arraymultiplier4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // accumulate one partial-product row per multiplier bit
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        p = p + ({4'b0000, a} << i);
      end
    end
  end

endmodule

// File: rtl/mul4_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // scan N slots starting at ptr, keep the first hit
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mul4_share_ctrl.sv
// Shares one 4x4 multiplier core among NREQ requesters.
// Accept in IDLE, evaluate in CALC, hold the result in HOLD.
module mul4_share_ctrl
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [OP_W*NREQ-1:0]   req_a,
  input  logic [OP_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PROD_W-1:0]      rsp_product,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  state_t state, state_n;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gidx;
  logic [NREQ-1:0]   grant;
  logic              any;
  logic              accept;
  logic [OP_W-1:0]   a_q, b_q;
  logic [IDW-1:0]    id_q;
  logic [PROD_W-1:0] core_p;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  Arraymultiplier4bit u_core (
    .a (a_q),
    .b (b_q),
    .p (core_p)
  );

  assign any       = |req_valid;
  assign accept    = (state == ST_IDLE) && any;
  assign rsp_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // next state and accept strobe; ready is masked while in reset
  always_comb begin
    state_n   = state;
    req_ready = '0;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_n   = ST_CALC;
          req_ready = rst ? '0 : grant;
        end
      end
      ST_CALC: state_n = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // operand capture on accept, result capture after the evaluate cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      if (accept) begin
        a_q  <= req_a[gidx*OP_W +: OP_W];
        b_q  <= req_b[gidx*OP_W +: OP_W];
        id_q <= gidx;
        ptr  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
      if (state == ST_CALC) begin
        rsp_product <= core_p;
        rsp_id      <= id_q;
      end
    end
  end

endmodule
